z80_dma_busmaster: RTL and testbench
====================================

// Module: z80_dma_busmaster
// PURPOSE
//  Memory-to-memory block-copy DMA engine sharing the 64 KB memory with the tv80s core.
//  Requests the bus via busrq_n/busak_n, copies bytes while the CPU is tristated, then returns the bus.
//  Releases the bus after at most BURST_MAX bytes so the CPU keeps making progress.
//  Sits beside tv80s; its mem_* outputs feed the memory mux, selected by bus_own.
// PARAMETERS
//  BURST_MAX  16  bytes copied per bus tenure before the bus is released (1..255)
//  GAP_CYC    4   clocks busrq_n is held high between tenures (>=1)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   one-cycle pulse; latches src/dst/len when idle
//  src         in   16  source start address
//  dst         in   16  destination start address
//  len         in   16  byte count; 0 = no transfer
//  busy        out  1   high from accepted start until done
//  done        out  1   one-cycle pulse at end of job (or abort)
//  err         out  1   sticky; set on bus loss mid-tenure, cleared by next accepted start
//  busrq_n     out  1   to tv80s busrq_n
//  busak_n     in   1   from tv80s busak_n
//  bus_own     out  1   high while DMA drives memory (mux select)
//  mem_a       out  16  memory address
//  mem_do      out  8   write data
//  mem_di      in   8   read data (memory registers data on negedge)
//  mem_mreq_n  out  1   memory request
//  mem_rd_n    out  1   read strobe
//  mem_wr_n    out  1   write strobe
// BEHAVIOUR
//  Reset: state IDLE; busrq_n=1, bus_own=0, mem_mreq_n=mem_rd_n=mem_wr_n=1, mem_a=0, mem_do=0,
//   busy=0, done=0, err=0. Reset mid-transfer drops busrq_n and bus_own on the next edge; no partial write.
//  States: IDLE, REQ, RD1, RD2, WR, REL, GAP.
//  IDLE: start & len!=0 -> latch src/dst/len, busy=1, clear err, REQ. start & len==0 -> done pulse, stay IDLE.
//   start while busy: ignored.
//  REQ: busrq_n=0. busak_n sampled 0 -> bus_own=1, tenure count=0, RD1.
//  RD1: mem_a=src_cur, mreq_n=rd_n=0. -> RD2.
//  RD2: strobes held; capture mem_di into data reg at end of cycle. -> WR.
//  WR: mem_a=dst_cur, mem_do=data reg, mreq_n=wr_n=0, rd_n=1. End of cycle: src_cur+1, dst_cur+1
//   (16-bit wrap FFFF->0000), remaining-1, tenure+1.
//   remaining==0 -> REL (job end). tenure==BURST_MAX -> REL (yield). Else -> RD1.
//  REL: strobes high, bus_own=0, busrq_n=1; wait for busak_n==1. Then: job end -> done pulse, busy=0, IDLE;
//   yield -> GAP.
//  GAP: count GAP_CYC clocks with busrq_n=1, then REQ.
//  Per byte: 3 clocks (RD1, RD2, WR). Grant latency is set by the CPU; no timeout.
//  Bus loss: busak_n sampled 1 while in RD1/RD2/WR -> strobes high immediately, err=1, done pulse,
//   busy=0, IDLE. The byte in flight is not written.
//  Overlapping src/dst ranges: byte-serial ascending copy; no overlap correction.
//  mem_a/mem_do hold their last value outside RD/WR states; strobes are never low when bus_own=0.
// STRUCTURE
//  Package z80_dma_pkg: state enum dma_state_t, BYTE_CYC=3 constant, addr_t (16 b) and data_t (8 b) typedefs.
//  Sub-module dma_xfer_counter: src/dst incrementers, remaining counter, tenure counter;
//   load/step inputs; last_byte and burst_full flags. FSM and bus strobes stay in the top level.
// TESTING
//  Bench: tv80s core running a NOP/JR loop, the negedge memory model, a mux on bus_own.
//  1 Reset: hold reset 3 clocks -> busrq_n=1, bus_own=0, all strobes 1, busy=0, err=0.
//  2 Single copy: mem[1000..1003]=11,22,33,44; start src=1000 dst=2000 len=4 -> mem[2000..2003]=11,22,33,44;
//    one tenure, 12 clocks from grant to REL, one done pulse, err=0.
//  3 Burst split: len=40, BURST_MAX=16 -> three tenures of 16/16/8 bytes; busrq_n high >= GAP_CYC between;
//    CPU PC advances between tenures; destination matches source.
//  4 Wrap: src=FFFE dst=0100 len=4 -> reads FFFE,FFFF,0000,0001 copied to 0100..0103.
//  5 Edge starts: len=0 -> done pulse in next clock, busrq_n never low; second start while busy -> ignored, job unchanged.
//  6 Faults: force busak_n=1 during RD2 of byte 3 -> err=1, done pulse, only 2 bytes written;
//    reset asserted in WR -> wr_n=1 and bus_own=0 on the next edge.

Source files
------------

// File: rtl/z80_dma_pkg.sv
// Shared types and constants for the z80_dma_busmaster block-copy engine.
// Contents:
//   dma_state_t : FSM state encoding
//   BYTE_CYC    : clocks spent on the bus per copied byte (RD1, RD2, WR)
//   addr_t      : 16-bit memory address
//   data_t      : 8-bit memory data
package z80_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD1,
    S_RD2,
    S_WR,
    S_REL,
    S_GAP
  } dma_state_t;

  localparam int BYTE_CYC = 3;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

endpackage

// File: rtl/dma_xfer_counter.sv
// Address and byte counters for the DMA engine.
// Ports:
//   clk        : clock
//   load       : latch src_in/dst_in/len_in at job start
//   step       : advance src/dst, decrement remaining, bump tenure (end of WR)
//   tenure_clr : restart the per-tenure byte count (bus granted)
//   src_in     : source start address
//   dst_in     : destination start address
//   len_in     : byte count of the job
//   src_cur    : current source address
//   dst_cur    : current destination address
//   src_next   : src_cur + 1, lets the FSM present the next read address from WR
//   last_byte  : the byte now being written is the final byte of the job
//   burst_full : the byte now being written fills the tenure to BURST_MAX
module dma_xfer_counter
  import z80_dma_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic  clk,
  input  logic  load,
  input  logic  step,
  input  logic  tenure_clr,
  input  addr_t src_in,
  input  addr_t dst_in,
  input  addr_t len_in,
  output addr_t src_cur,
  output addr_t dst_cur,
  output addr_t src_next,
  output logic  last_byte,
  output logic  burst_full
);

  addr_t       remaining;
  logic [7:0]  tenure;

  // Datapath registers: always loaded before use, so no reset is needed.
  always_ff @(posedge clk) begin
    if (load) begin
      src_cur   <= src_in;
      dst_cur   <= dst_in;
      remaining <= len_in;
    end else if (step) begin
      src_cur   <= src_cur + 16'd1;
      dst_cur   <= dst_cur + 16'd1;
      remaining <= remaining - 16'd1;
    end

    if (tenure_clr) begin
      tenure <= 8'd0;
    end else if (step) begin
      tenure <= tenure + 8'd1;
    end
  end

  assign src_next   = src_cur + 16'd1;
  // Flags look one byte ahead so the decision is made during WR itself.
  assign last_byte  = (remaining == 16'd1);
  assign burst_full = (tenure == 8'(BURST_MAX - 1));

endmodule

// File: rtl/z80_dma_busmaster.sv
// Memory-to-memory block-copy DMA engine sharing memory with a tv80s core.
// Requests the bus with busrq_n, copies up to BURST_MAX bytes per tenure
// (three clocks per byte), releases the bus, waits GAP_CYC clocks so the CPU
// can run, and repeats until the job is done.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, src, dst, len: job request (len==0 completes immediately)
//   busy, done, err     : job status (done is a pulse, err is sticky)
//   busrq_n, busak_n    : CPU bus request / acknowledge
//   bus_own             : memory mux select, high while DMA drives memory
//   mem_a, mem_do       : memory address / write data
//   mem_di              : memory read data
//   mem_mreq_n, mem_rd_n, mem_wr_n : memory strobes
module z80_dma_busmaster
  import z80_dma_pkg::*;
#(
  parameter int BURST_MAX = 16,
  parameter int GAP_CYC   = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  input  addr_t src,
  input  addr_t dst,
  input  addr_t len,
  output logic  busy,
  output logic  done,
  output logic  err,
  output logic  busrq_n,
  input  logic  busak_n,
  output logic  bus_own,
  output addr_t mem_a,
  output data_t mem_do,
  input  data_t mem_di,
  output logic  mem_mreq_n,
  output logic  mem_rd_n,
  output logic  mem_wr_n
);

  dma_state_t  state;
  logic        job_end;
  logic [15:0] gap_cnt;

  addr_t src_cur, dst_cur, src_next;
  logic  last_byte, burst_full;
  logic  cnt_load, cnt_step, cnt_tenure_clr;

  assign cnt_load       = (state == S_IDLE) && start && (len != 16'd0);
  assign cnt_step       = (state == S_WR) && !busak_n;
  assign cnt_tenure_clr = (state == S_REQ) && !busak_n;

  dma_xfer_counter #(
    .BURST_MAX (BURST_MAX)
  ) u_cnt (
    .clk        (clk),
    .load       (cnt_load),
    .step       (cnt_step),
    .tenure_clr (cnt_tenure_clr),
    .src_in     (src),
    .dst_in     (dst),
    .len_in     (len),
    .src_cur    (src_cur),
    .dst_cur    (dst_cur),
    .src_next   (src_next),
    .last_byte  (last_byte),
    .burst_full (burst_full)
  );

  // All bus outputs are registered: each is set on the edge that enters the
  // state in which it must be valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busrq_n    <= 1'b1;
      bus_own    <= 1'b0;
      mem_mreq_n <= 1'b1;
      mem_rd_n   <= 1'b1;
      mem_wr_n   <= 1'b1;
      mem_a      <= '0;
      mem_do     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      job_end    <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (len != 16'd0) begin
              busy    <= 1'b1;
              err     <= 1'b0;
              busrq_n <= 1'b0;
              state   <= S_REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (!busak_n) begin
            bus_own    <= 1'b1;
            mem_a      <= src_cur;
            mem_mreq_n <= 1'b0;
            mem_rd_n   <= 1'b0;
            state      <= S_RD1;
          end
        end

        S_RD1, S_RD2, S_WR: begin
          if (busak_n) begin
            // Bus taken away mid-tenure: drop everything and abort the job.
            mem_mreq_n <= 1'b1;
            mem_rd_n   <= 1'b1;
            mem_wr_n   <= 1'b1;
            bus_own    <= 1'b0;
            busrq_n    <= 1'b1;
            err        <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (state == S_RD1) begin
            state <= S_RD2;
          end else if (state == S_RD2) begin
            // mem_do doubles as the byte holding register.
            mem_do   <= mem_di;
            mem_a    <= dst_cur;
            mem_rd_n <= 1'b1;
            mem_wr_n <= 1'b0;
            state    <= S_WR;
          end else if (last_byte || burst_full) begin
            job_end    <= last_byte;
            mem_mreq_n <= 1'b1;
            mem_wr_n   <= 1'b1;
            bus_own    <= 1'b0;
            busrq_n    <= 1'b1;
            state      <= S_REL;
          end else begin
            mem_a    <= src_next;
            mem_wr_n <= 1'b1;
            mem_rd_n <= 1'b0;
            state    <= S_RD1;
          end
        end

        S_REL: begin
          if (busak_n) begin
            if (job_end) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == 16'(GAP_CYC - 1)) begin
            busrq_n <= 1'b0;
            state   <= S_REQ;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_dma_busmaster.sv
// Directed bench for z80_dma_busmaster: a CPU stand-in that grants the bus
// two clocks after request and runs a free-running PC while it owns the bus,
// a negedge memory model, and monitors that log tenures and request gaps.
module tb_z80_dma_busmaster;
  import z80_dma_pkg::*;

  localparam int BURST_MAX = 16;
  localparam int GAP_CYC   = 4;

  logic  clk = 1'b0;
  logic  reset, start;
  addr_t src, dst, len;
  logic  busy, done, err, busrq_n, busak_n, bus_own;
  addr_t mem_a;
  data_t mem_do, mem_di;
  logic  mem_mreq_n, mem_rd_n, mem_wr_n;

  always #5 clk = ~clk;

  z80_dma_busmaster #(.BURST_MAX(BURST_MAX), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .err(err), .busrq_n(busrq_n), .busak_n(busak_n),
    .bus_own(bus_own), .mem_a(mem_a), .mem_do(mem_do), .mem_di(mem_di),
    .mem_mreq_n(mem_mreq_n), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n)
  );

  // CPU stand-in
  logic ack_d1, cpu_ack_n, force_loss;
  int   pc = 0;
  always @(posedge clk) begin
    if (reset) begin
      ack_d1    <= 1'b1;
      cpu_ack_n <= 1'b1;
    end else begin
      ack_d1    <= busrq_n;
      cpu_ack_n <= ack_d1;
    end
    if (cpu_ack_n) pc <= pc + 1;
  end
  assign busak_n = cpu_ack_n | force_loss;

  // Memory model, with a backdoor port for preloading
  logic [7:0] mem [0:65535];
  logic       tb_we;
  addr_t      tb_wa;
  data_t      tb_wd;
  always @(negedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (bus_own && !mem_mreq_n && !mem_wr_n) mem[mem_a] <= mem_do;
    if (bus_own && !mem_mreq_n && !mem_rd_n) mem_di <= mem[mem_a];
  end

  // Monitors
  logic prev_own = 1'b0, prev_rq = 1'b1;
  int done_cnt = 0, wr_cnt = 0, viol = 0, ten_cnt = 0, req_cnt = 0;
  int own_len = 0, ten_bytes = 0, rq_run = 0;
  int len_arr [0:31];
  int bytes_arr [0:31];
  int pc_start [0:31];
  int pc_end [0:31];
  int gap_arr [0:31];
  always @(negedge clk) begin
    prev_own <= bus_own;
    prev_rq  <= busrq_n;
    if (done) done_cnt <= done_cnt + 1;
    if (!mem_wr_n && !mem_mreq_n) wr_cnt <= wr_cnt + 1;
    if (!bus_own && (!mem_mreq_n || !mem_rd_n || !mem_wr_n)) viol <= viol + 1;
    if (bus_own && !prev_own) begin
      ten_cnt <= ten_cnt + 1;
      own_len <= 1;
      ten_bytes <= 0;
      pc_start[5'(ten_cnt)] <= pc;
    end else if (bus_own) begin
      own_len <= own_len + 1;
      if (!mem_wr_n) ten_bytes <= ten_bytes + 1;
    end
    if (!bus_own && prev_own) begin
      len_arr[5'(ten_cnt - 1)]   <= own_len;
      bytes_arr[5'(ten_cnt - 1)] <= ten_bytes;
      pc_end[5'(ten_cnt - 1)]    <= pc;
    end
    if (busrq_n) rq_run <= rq_run + 1;
    else if (prev_rq) begin
      gap_arr[5'(req_cnt)] <= rq_run;
      req_cnt <= req_cnt + 1;
      rq_run  <= 0;
    end
  end

  int checks = 0, errors = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic poke(input addr_t a, input data_t d);
    tb_wa = a; tb_wd = d; tb_we = 1'b1;
    @(negedge clk); #1 tb_we = 1'b0;
  endtask

  task automatic start_job(input addr_t s, input addr_t d, input addr_t l);
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check1(tag, done, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tb, rb, db, wb, bad;
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    force_loss = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

    // 1 reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_busrq_n", busrq_n, 1'b1);
    check1("rst_bus_own", bus_own, 1'b0);
    check1("rst_mreq_n", mem_mreq_n, 1'b1);
    check1("rst_rd_n", mem_rd_n, 1'b1);
    check1("rst_wr_n", mem_wr_n, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("rst_mem_a", 32'(mem_a), 32'h0);
    check32("rst_mem_do", 32'(mem_do), 32'h0);
    reset = 1'b0;

    // 2 single copy
    poke(16'h1000, 8'h11); poke(16'h1001, 8'h22);
    poke(16'h1002, 8'h33); poke(16'h1003, 8'h44);
    tb = ten_cnt; db = done_cnt;
    start_job(16'h1000, 16'h2000, 16'd4);
    check1("single_busy", busy, 1'b1);
    wait_done("single_done", 500);
    repeat (2) @(negedge clk);
    check32("single_data", {mem[16'h2000], mem[16'h2001], mem[16'h2002], mem[16'h2003]}, 32'h11223344);
    check32("single_tenures", ten_cnt - tb, 32'd1);
    check32("single_own_clocks", len_arr[5'(tb)], 32'(4 * BYTE_CYC));
    check32("single_bytes", bytes_arr[5'(tb)], 32'd4);
    check32("single_done_cnt", done_cnt - db, 32'd1);
    check1("single_err", err, 1'b0);
    check1("single_idle", busy, 1'b0);

    // 3 burst split, 40 bytes
    for (int i = 0; i < 40; i++) poke(16'(16'h4000 + i), 8'(i * 3 + 7));
    tb = ten_cnt; rb = req_cnt;
    start_job(16'h4000, 16'h5000, 16'd40);
    wait_done("burst_done", 3000);
    repeat (2) @(negedge clk);
    check32("burst_tenures", ten_cnt - tb, 32'd3);
    check32("burst_bytes0", bytes_arr[5'(tb)], 32'd16);
    check32("burst_bytes1", bytes_arr[5'(tb + 1)], 32'd16);
    check32("burst_bytes2", bytes_arr[5'(tb + 2)], 32'd8);
    // REL waits 3 clocks for the stand-in to drop busak_n, then GAP_CYC clocks
    check32("burst_gap1", gap_arr[5'(rb + 1)], 32'(3 + GAP_CYC));
    check32("burst_gap2", gap_arr[5'(rb + 2)], 32'(3 + GAP_CYC));
    check1("burst_pc_adv1", pc_start[5'(tb + 1)] > pc_end[5'(tb)], 1'b1);
    check1("burst_pc_adv2", pc_start[5'(tb + 2)] > pc_end[5'(tb + 1)], 1'b1);
    bad = 0;
    for (int i = 0; i < 40; i++) if (mem[16'(16'h5000 + i)] !== 8'(i * 3 + 7)) bad++;
    check32("burst_data_mismatches", bad, 32'd0);

    // 4 address wrap
    poke(16'hFFFE, 8'hA1); poke(16'hFFFF, 8'hB2);
    poke(16'h0000, 8'hC3); poke(16'h0001, 8'hD4);
    start_job(16'hFFFE, 16'h0100, 16'd4);
    wait_done("wrap_done", 500);
    check32("wrap_data", {mem[16'h0100], mem[16'h0101], mem[16'h0102], mem[16'h0103]}, 32'hA1B2C3D4);

    // 5a zero length
    @(negedge clk);
    rb = req_cnt;
    start_job(16'h1000, 16'h2100, 16'd0);
    check1("zero_done", done, 1'b1);
    check1("zero_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check32("zero_no_request", req_cnt - rb, 32'd0);
    check1("zero_busrq_n", busrq_n, 1'b1);

    // 5b start while busy is ignored
    db = done_cnt; wb = wr_cnt;
    start_job(16'h1000, 16'h3000, 16'd4);
    repeat (3) @(negedge clk);
    start_job(16'h1100, 16'h3100, 16'd8);
    wait_done("ignore_done", 500);
    repeat (2) @(negedge clk);
    check32("ignore_data", {mem[16'h3000], mem[16'h3001], mem[16'h3002], mem[16'h3003]}, 32'h11223344);
    check32("ignore_untouched", 32'(mem[16'h3100]), 32'h0);
    check32("ignore_writes", wr_cnt - wb, 32'd4);
    check32("ignore_done_cnt", done_cnt - db, 32'd1);

    // 6a bus loss during RD2 of byte 3
    for (int i = 0; i < 4; i++) poke(16'(16'h6000 + i), 8'hEE);
    wb = wr_cnt;
    start_job(16'h1000, 16'h6000, 16'd4);
    for (int n = 0; n < 500 && !(wr_cnt == wb + 2 && !mem_rd_n); n++) @(negedge clk);
    check1("loss_reached_rd1", (wr_cnt == wb + 2) && !mem_rd_n, 1'b1);
    @(posedge clk); #1 force_loss = 1'b1;
    wait_done("loss_done", 20);
    check1("loss_err", err, 1'b1);
    check1("loss_busy", busy, 1'b0);
    check1("loss_bus_own", bus_own, 1'b0);
    check1("loss_wr_n", mem_wr_n, 1'b1);
    force_loss = 1'b0;
    repeat (3) @(negedge clk);
    check32("loss_writes", wr_cnt - wb, 32'd2);
    check32("loss_data", {mem[16'h6000], mem[16'h6001], mem[16'h6002], mem[16'h6003]}, 32'h1122EEEE);
    check1("loss_err_sticky", err, 1'b1);

    // 6b reset while in WR
    start_job(16'h1000, 16'h7000, 16'd4);
    check1("restart_err_clear", err, 1'b0);
    for (int n = 0; n < 500 && mem_wr_n; n++) @(negedge clk);
    check1("rstwr_reached_wr", mem_wr_n, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check1("rstwr_wr_n", mem_wr_n, 1'b1);
    check1("rstwr_bus_own", bus_own, 1'b0);
    check1("rstwr_busrq_n", busrq_n, 1'b1);
    check1("rstwr_mreq_n", mem_mreq_n, 1'b1);
    check1("rstwr_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check32("strobe_without_bus", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
